// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply controller and the EX-stage decoder.
package muldiv_pkg;

  localparam int unsigned MUL_W    = 32;
  localparam int unsigned MUL_ITER = 32;
  localparam int unsigned OP_W     = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_MTHI  = 3'd3,
    OP_MTLO  = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_FIX     = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

  typedef struct packed {
    logic [MUL_W-1:0] hi;
    logic [MUL_W-1:0] lo;
  } hilo_t;

  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_if.sv
// EX-stage side of the HI/LO controller: requests, reads, squash and results.
interface muldiv_hilo_ctrl_if;
  import muldiv_pkg::*;

  logic                 req_valid;
  logic [OP_W-1:0]      req_op;
  logic [MUL_W-1:0]     req_a;
  logic [MUL_W-1:0]     req_b;
  logic                 hilo_rd;
  logic                 flush;
  logic                 stall_req;
  logic                 busy;
  logic [MUL_W-1:0]     hi;
  logic [MUL_W-1:0]     lo;

  modport master (
    output req_valid, req_op, req_a, req_b, hilo_rd, flush,
    input  stall_req, busy, hi, lo
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, hilo_rd, flush,
    output stall_req, busy, hi, lo
  );

endinterface

// File: rtl/hilo_fix.sv
// Converts the signed core product's upper half into the unsigned MULTU result.
module hilo_fix
  import muldiv_pkg::*;
(
  input  logic [MUL_W-1:0] z_hi,
  input  logic [MUL_W-1:0] a,
  input  logic [MUL_W-1:0] b,
  output logic [MUL_W-1:0] hi_c
);

  logic [MUL_W-1:0] add_b_c;
  logic [MUL_W-1:0] add_a_c;

  // A negative signed operand stands for operand + 2^32; each adds the other operand to HI.
  always_comb begin
    add_b_c = a[MUL_W-1] ? b : '0;
    add_a_c = b[MUL_W-1] ? a : '0;
    hi_c    = z_hi + add_b_c + add_a_c;
  end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Sequences the shared Booth multiplier core, owns HI/LO and stalls EX while a product is pending.
module muldiv_hilo_ctrl
  import muldiv_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  muldiv_hilo_ctrl_if.slave    bus,
  output logic                 mul_start,
  output logic [MUL_W-1:0]     mul_a,
  output logic [MUL_W-1:0]     mul_b,
  input  logic [2*MUL_W-1:0]   mul_z,
  input  logic                 mul_finish
);

  state_e           state_q;
  state_e           state_d;
  logic [MUL_W-1:0] a_q;
  logic [MUL_W-1:0] b_q;
  logic             uns_q;
  hilo_t            z_q;
  logic [MUL_W-1:0] hi_q;
  logic [MUL_W-1:0] lo_q;
  logic             busy_q;

  logic             accept_c;
  logic             latch_op_c;
  logic             latch_z_c;
  logic             wr_full_c;
  logic             wr_fix_c;
  logic             wr_hi_c;
  logic             wr_lo_c;
  logic [MUL_W-1:0] fix_hi_c;

  assign accept_c = bus.req_valid & ~bus.flush;
  assign mul_a    = bus.req_a;
  assign mul_b    = bus.req_b;

  hilo_fix u_fix (
    .z_hi (z_q.hi),
    .a    (a_q),
    .b    (b_q),
    .hi_c (fix_hi_c)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: a flush that coincides with finish needs no DISCARD wait
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c && is_mul_op(bus.req_op)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.flush)       state_d = mul_finish ? ST_IDLE : ST_DISCARD;
        else if (mul_finish) state_d = uns_q ? ST_FIX : ST_IDLE;
      end
      ST_FIX:     state_d = ST_IDLE;
      ST_DISCARD: begin
        if (mul_finish) state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath strobes
  always_comb begin
    mul_start     = 1'b0;
    latch_op_c    = 1'b0;
    latch_z_c     = 1'b0;
    wr_full_c     = 1'b0;
    wr_fix_c      = 1'b0;
    wr_hi_c       = 1'b0;
    wr_lo_c       = 1'b0;
    bus.stall_req = busy_q & (bus.hilo_rd | (bus.req_valid & (bus.req_op != OP_NONE)));
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          mul_start  = is_mul_op(bus.req_op);
          latch_op_c = is_mul_op(bus.req_op);
          wr_hi_c    = (bus.req_op == OP_MTHI);
          wr_lo_c    = (bus.req_op == OP_MTLO);
        end
      end
      ST_RUN: begin
        if (mul_finish && !bus.flush) begin
          wr_full_c = ~uns_q;
          latch_z_c = uns_q;
        end
      end
      ST_FIX:  wr_fix_c = ~bus.flush;
      default: ;
    endcase
  end

  // Operand and raw product capture for the MULTU correction cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      uns_q <= 1'b0;
      z_q   <= '0;
    end else begin
      if (latch_op_c) begin
        a_q   <= bus.req_a;
        b_q   <= bus.req_b;
        uns_q <= (bus.req_op == OP_MULTU);
      end
      if (latch_z_c) z_q <= hilo_t'(mul_z);
    end
  end

  // Architectural HI/LO and busy flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      busy_q <= (state_d != ST_IDLE);
      if (wr_full_c) begin
        hi_q <= mul_z[2*MUL_W-1:MUL_W];
        lo_q <= mul_z[MUL_W-1:0];
      end else if (wr_fix_c) begin
        hi_q <= fix_hi_c;
        lo_q <= z_q.lo;
      end else begin
        if (wr_hi_c) hi_q <= bus.req_a;
        if (wr_lo_c) lo_q <= bus.req_a;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Scoreboarded bench for muldiv_hilo_ctrl with a behavioural 33-cycle signed multiplier core.
`timescale 1ns/1ps
module tb_muldiv_hilo_ctrl;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  muldiv_hilo_ctrl_if bus();

  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_z;
  logic        mul_finish;

  muldiv_hilo_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_z      (mul_z),
    .mul_finish (mul_finish)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: signed product, finish 33 cycles after the start cycle
  int unsigned core_cnt;
  logic [63:0] core_z;

  function automatic logic [63:0] core_mul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return 64'(sa * sb);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_cnt <= 0;
      core_z   <= '0;
    end else if (mul_start) begin
      core_cnt <= MUL_ITER + 1;
      core_z   <= core_mul(mul_a, mul_b);
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
    end
  end
  assign mul_finish = (core_cnt == 1);
  assign mul_z      = mul_finish ? core_z : 64'hDEAD_BEEF_DEAD_BEEF;

  // Reference: architectural result of each instruction
  function automatic logic [63:0] ref_product(input op_e op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (op == OP_MULTU) p = {32'b0, a} * {32'b0, b};
    else                p = $signed(a) * $signed(b);
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          exp_cyc;
    string       name;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] ref_hi = '0;
  logic [31:0] ref_lo = '0;

  // Monitor: each busy fall completes one multiply; compare HI/LO and completion cycle
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    if (busy_prev && !bus.busy) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: busy fell at cycle %0d with nothing pending", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check({e.name, "_hi"}, 64'(bus.hi), 64'(e.hi));
        check({e.name, "_lo"}, 64'(bus.lo), 64'(e.lo));
        if (e.exp_cyc >= 0) check({e.name, "_cycle"}, 64'(cyc), 64'(e.exp_cyc));
      end
    end
    busy_prev <= bus.busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, hold it while stalled, return acceptance cycle and stalled cycles
  task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] b, input logic fl,
                       output int t_acc, output int stalled);
    stalled = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.flush     = fl;
    #1;
    while (bus.stall_req && stalled < 200) begin
      tick();
      stalled++;
      #1;
    end
    if (stalled >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: stall_req never dropped, got 1 expected 0");
    end
    t_acc = cyc;
    tick();
    bus.req_valid = 1'b0;
    bus.req_op    = OP_NONE;
    bus.flush     = 1'b0;
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while (bus.busy && waited < 100) begin
      tick();
      waited++;
    end
    if (waited >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: busy got 1 expected 0");
    end
  endtask

  // Multiply with optional squash flush_at cycles after acceptance (0 = none)
  task automatic do_mul(input op_e op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input string name, output int t);
    int st;
    int exp_c;
    logic [63:0] p;
    issue(op, a, b, 1'b0, t, st);
    p = ref_product(op, a, b);
    if (flush_at == 0) begin
      ref_hi = p[63:32];
      ref_lo = p[31:0];
      exp_c  = t + ((op == OP_MULTU) ? 35 : 34);
    end else begin
      exp_c  = t + ((op == OP_MULTU && flush_at == 34) ? 35 : 34);
    end
    sbq.push_back('{ref_hi, ref_lo, exp_c, name});
    if (flush_at != 0) begin
      while (cyc < t + flush_at) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
    end
    wait_idle();
  endtask

  task automatic do_mt(input op_e op, input logic [31:0] a, input string name, output int stalled);
    int t;
    issue(op, a, 32'h0, 1'b0, t, stalled);
    if (op == OP_MTHI) ref_hi = a;
    else               ref_lo = a;
    #1;
    check({name, "_hi"}, 64'(bus.hi), 64'(ref_hi));
    check({name, "_lo"}, 64'(bus.lo), 64'(ref_lo));
  endtask

  // MFHI/MFLO held in EX from T+1: stalled until the result is visible
  task automatic mf_watch(input op_e op, input logic [31:0] a, input logic [31:0] b, input string name);
    int t;
    int st;
    int lat;
    logic [63:0] p;
    issue(op, a, b, 1'b0, t, st);
    p   = ref_product(op, a, b);
    ref_hi = p[63:32];
    ref_lo = p[31:0];
    lat = (op == OP_MULTU) ? 35 : 34;
    sbq.push_back('{ref_hi, ref_lo, t + lat, name});
    bus.hilo_rd = 1'b1;
    for (int k = 0; k < 60; k++) begin
      #1;
      check({name, "_stall"}, 64'(bus.stall_req), 64'(cyc < t + lat));
      if (!bus.stall_req) begin
        check({name, "_rd_hi"}, 64'(bus.hi), 64'(ref_hi));
        break;
      end
      tick();
    end
    bus.hilo_rd = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 4))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t;
    int t2;
    int st;
    bus.req_valid = 1'b0;
    bus.req_op    = OP_NONE;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.hilo_rd   = 1'b0;
    bus.flush     = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    check("rst_hi",    64'(bus.hi),        64'h0);
    check("rst_lo",    64'(bus.lo),        64'h0);
    check("rst_busy",  64'(bus.busy),      64'h0);
    check("rst_stall", 64'(bus.stall_req), 64'h0);

    do_mt(OP_MTHI, 32'h1234_5678, "mthi_idle", st);
    check("mthi_idle_stall", 64'(st), 64'h0);

    do_mul(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 0, "mult_m3x7", t);
    check("mult_m3x7_hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
    check("mult_m3x7_lo_const", 64'(bus.lo), 64'hFFFF_FFEB);

    do_mul(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max", t);
    check("multu_max_hi_const", 64'(bus.hi), 64'hFFFF_FFFE);
    check("multu_max_lo_const", 64'(bus.lo), 64'h1);

    do_mul(OP_MULTU, 32'h8000_0000, 32'h0000_0002, 0, "multu_msb", t);
    check("multu_msb_hi_const", 64'(bus.hi), 64'h1);
    check("multu_msb_lo_const", 64'(bus.lo), 64'h0);

    mf_watch(OP_MULT,  32'h0000_1234, 32'hFFFF_FFFB, "mfhi_mult");
    mf_watch(OP_MULTU, 32'hC000_0001, 32'h9000_0003, "mfhi_multu");

    do_mul(OP_MULT, 32'd5, 32'd5, 10, "flush_t10", t);
    do_mul(OP_MULT, 32'd6, 32'd7, 0, "after_flush", t2);
    check("after_flush_accept", 64'(t2), 64'(t + 34));

    // MTLO presented during RUN is held off until IDLE, then written
    issue(OP_MULT, 32'h11, 32'h3, 1'b0, t, st);
    ref_hi = 32'h0;
    ref_lo = 32'h33;
    sbq.push_back('{ref_hi, ref_lo, t + 34, "mult_then_mtlo"});
    while (cyc < t + 5) tick();
    do_mt(OP_MTLO, 32'hCAFE_F00D, "mtlo_run", st);
    check("mtlo_run_stalled", 64'(st), 64'd29);

    // Request squashed in the same cycle is ignored
    issue(OP_MULT, 32'd9, 32'd9, 1'b1, t, st);
    #1;
    check("flush_req_busy", 64'(bus.busy), 64'h0);
    check("flush_req_hi",   64'(bus.hi),   64'(ref_hi));
    check("flush_req_lo",   64'(bus.lo),   64'(ref_lo));
    tick();

    // Reset mid-operation abandons the product
    issue(OP_MULT, 32'd7, 32'd9, 1'b0, t, st);
    ref_hi = '0;
    ref_lo = '0;
    sbq.push_back('{ref_hi, ref_lo, -1, "reset_abort"});
    while (cyc < t + 15) tick();
    reset = 1'b0;
    #1;
    check("rst_mid_busy", 64'(bus.busy), 64'h0);
    check("rst_mid_hi",   64'(bus.hi),   64'h0);
    check("rst_mid_lo",   64'(bus.lo),   64'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    do_mul(OP_MULT, 32'd2, 32'd3, 0, "mult_2x3", t);
    check("mult_2x3_lo_const", 64'(bus.lo), 64'd6);
    check("mult_2x3_hi_const", 64'(bus.hi), 64'd0);

    for (int i = 0; i < 24; i++) begin
      int r;
      logic [31:0] a;
      logic [31:0] b;
      r = $urandom_range(0, 9);
      a = rnd_operand();
      b = rnd_operand();
      case (r)
        0, 1, 2: do_mul(OP_MULT,  a, b, 0, "rnd_mult",  t);
        3, 4, 5: do_mul(OP_MULTU, a, b, 0, "rnd_multu", t);
        6:       do_mt(OP_MTHI, a, "rnd_mthi", st);
        7:       do_mt(OP_MTLO, a, "rnd_mtlo", st);
        8:       do_mul(OP_MULT,  a, b, $urandom_range(1, 33), "rnd_mult_flush",  t);
        default: do_mul(OP_MULTU, a, b, $urandom_range(1, 34), "rnd_multu_flush", t);
      endcase
    end

    repeat (5) tick();
    check("sb_drained", 64'(sbq.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
